keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter BOUNCE_CYC, default 200: cycles of contact bounce on press and on release (0 = no bounce phases).
REQ-002 SHALL have parameter BOUNCE_DIV, default 4: cycles between bounce-LFSR steps (minimum 1).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  press request valid.
REQ-006 SHALL have port req_ready  out  1  emulator can accept a request.
REQ-007 SHALL have port req_key  in  5  key code: 0-15 = key; 16-31 = no key (timed idle).
REQ-008 SHALL have port req_hold  in  16  stable-closed hold length in cycles.
REQ-009 SHALL have port col  in  4  scanner column drive, active-low.
REQ-010 SHALL have port row  out  4  row return to scanner, active-low, idle 4'b1111.
REQ-011 SHALL have port busy  out  1  request in progress.
REQ-012 SHALL have port done  out  1  one-cycle pulse at completion of a request.

Function
REQ-013 SHALL decode the key as row index r = key[3:2] and column index c = key[1:0] (key 1 -> r0,c1; key 7 -> r1,c3; key 10 -> r2,c2).
REQ-014 SHALL drive row[r] = col[c] combinationally while contact = 1, and every other row bit to 1; with contact = 0, row SHALL be 4'b1111 (zero-latency col-to-row path).
REQ-015 SHALL implement FSM states IDLE, PRESS_BOUNCE, HOLD, REL_BOUNCE.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, latching req_key and req_hold.
REQ-017 SHALL ignore req_valid outside IDLE, with no latching and no state effect.
REQ-018 SHALL make transitions: IDLE->PRESS_BOUNCE on accept; PRESS_BOUNCE->HOLD after BOUNCE_CYC cycles; HOLD->REL_BOUNCE after Hc cycles; REL_BOUNCE->IDLE after BOUNCE_CYC cycles.
REQ-019 SHALL define Hc = req_hold, except req_hold = 0 gives Hc = 1.
REQ-020 SHALL, when BOUNCE_CYC = 0, skip both bounce states (IDLE->HOLD, HOLD->IDLE).
REQ-021 SHALL set contact as follows: IDLE contact = 0; HOLD contact = 1; bounce states contact = lfsr[0].
REQ-022 SHALL use an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, stepping once every BOUNCE_DIV cycles and only in bounce states; the value is retained between requests.
REQ-023 SHALL force contact = 0 for the whole request when the latched key >= 16, with FSM timing unchanged.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL assert done for exactly the first IDLE cycle following REL_BOUNCE (or HOLD when BOUNCE_CYC = 0); req_ready is also 1 in that cycle.
REQ-026 SHALL place done exactly 2*BOUNCE_CYC + Hc cycles after the accept edge.
REQ-027 SHALL accept a back-to-back request in the done cycle.
REQ-028 SHALL use a 16-bit phase counter that does not wrap; each phase ends on a terminal-count compare.

Reset
REQ-029 SHALL, on a rising edge with rst_n = 0, set state IDLE, contact 0, LFSR 8'hA5, counters 0, busy 0, done 0.
REQ-030 SHALL produce the reset output values row = 4'b1111 and req_ready = 1 from the next cycle onward.
REQ-031 SHALL, on reset mid-request, abort the request with no done pulse, and row SHALL return to 4'b1111 after that edge.

Verification (BOUNCE_CYC=8, BOUNCE_DIV=2)
REQ-032 SHALL verify reset: rst_n low 2 cycles, col=4'b0000 -> row=4'b1111, req_ready=1, busy=0, done=0.
REQ-033 SHALL verify key 1: req_key=1, req_hold=10; during HOLD col=4'b1101 -> row=4'b1110, and col=4'b1110 -> row=4'b1111; done exactly 26 cycles after accept.
REQ-034 SHALL verify keys 10 and 7: key 10, col=4'b1011 in HOLD -> row=4'b1011; key 7, col=4'b0111 in HOLD -> row=4'b1101; other col patterns -> 4'b1111.
REQ-035 SHALL verify bounce: during PRESS_BOUNCE with col[c]=0, row[r] follows the lfsr[0] reference model from seed 8'hA5, stepping every 2 cycles; the bench SHALL check at least one 0<->1 transition.
REQ-036 SHALL verify busy and idle requests: req_valid pulsed mid-request -> ignored, req_ready=0; req_key=16, req_hold=0 -> row 4'b1111 throughout, done 17 cycles after accept.
REQ-037 SHALL verify mid-HOLD reset: rst_n low 1 cycle during HOLD -> next cycle row=4'b1111, busy=0, req_ready=1, no done pulse.

Source files
------------

// File: rtl/keypad_emulator.sv
// Keypad contact emulator: presses one key of a 4x4 matrix for a requested time,
// with LFSR-driven contact bounce on press and release, seen through the scanner's col->row path.
module keypad_emulator #(
    parameter int BOUNCE_CYC = 200,
    parameter int BOUNCE_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_key,
    input  logic [15:0] req_hold,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        busy,
    output logic        done
);

    localparam int          DIV    = (BOUNCE_DIV < 1) ? 1 : BOUNCE_DIV;
    localparam logic [15:0] DIV_TC = 16'(DIV - 1);
    localparam logic [15:0] BNC_TC = 16'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam bit          NO_BNC = (BOUNCE_CYC == 0);

    typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HOLD, REL_BOUNCE} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] hold_tc_q;
    logic [15:0] div_q;
    logic [7:0]  lfsr_q;
    logic [4:0]  key_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    logic        in_bounce;
    logic        lfsr_fb;
    logic        contact;

    assign in_bounce = (state_q == PRESS_BOUNCE) || (state_q == REL_BOUNCE);
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    // Codes 16-31 are timed idles: the FSM runs but the contact never closes.
    assign contact   = !key_q[4] && ((state_q == HOLD) || (in_bounce && lfsr_q[0]));

    always_comb begin
        row = 4'b1111;
        if (contact) row[key_q[3:2]] = col[key_q[1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            hold_tc_q <= 16'd0;
            div_q     <= 16'd0;
            lfsr_q    <= 8'hA5;
            key_q     <= 5'd0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // LFSR state survives between requests so successive presses bounce differently.
            if (in_bounce) begin
                if (div_q == DIV_TC) begin
                    div_q  <= 16'd0;
                    lfsr_q <= {lfsr_q[6:0], lfsr_fb};
                end else begin
                    div_q <= div_q + 16'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        key_q     <= req_key;
                        hold_tc_q <= (req_hold == 16'd0) ? 16'd0 : req_hold - 16'd1;
                        cnt_q     <= 16'd0;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= NO_BNC ? HOLD : PRESS_BOUNCE;
                    end
                end
                PRESS_BOUNCE: begin
                    if (cnt_q == BNC_TC) begin
                        cnt_q   <= 16'd0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == hold_tc_q) begin
                        cnt_q <= 16'd0;
                        if (NO_BNC) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= REL_BOUNCE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                REL_BOUNCE: begin
                    if (cnt_q == BNC_TC) begin
                        cnt_q   <= 16'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator against a per-request timeline model
// (phase from cycles-since-accept, bounce value from the LFSR stepped from seed).
module tb_keypad_emulator;
    localparam int B = 8;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_key = 5'd0;
    logic [15:0] req_hold = 16'd0;
    logic [3:0]  col = 4'd0;
    logic [3:0]  row;
    logic        busy;
    logic        done;

    keypad_emulator #(.BOUNCE_CYC(B), .BOUNCE_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_hold(req_hold), .col(col), .row(row),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit         m_busy = 0, m_done = 0;
    int         m_t = 0, m_hc = 1, m_nb = 0;
    logic [4:0] m_key = 5'd0;
    int         cyc = 0, acc_cyc = 0, tog = 0;
    logic       prev_r = 1'b0;
    bit         prev_vld = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] l = 8'hA5;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    // 0 idle, 1 press bounce, 2 hold, 3 release bounce
    function automatic int phase();
        if (!m_busy) return 0;
        if (m_t < B) return 1;
        if (m_t < B + m_hc) return 2;
        return 3;
    endfunction

    task automatic cycle();
        int ph;
        logic ct;
        logic [3:0] er;
        @(negedge clk);
        ph = phase();
        ct = 1'b0;
        if (!m_key[4]) begin
            if (ph == 2) ct = 1'b1;
            else if (ph == 1 || ph == 3) ct = lfsr_at(m_nb / D) ;
        end
        if (ph == 0 || m_key[4]) ct = 1'b0;
        else if (ph != 2) ct = lfsr_at(m_nb / D) & 8'h01 ? 1'b1 : 1'b0;
        er = 4'b1111;
        if (ct) er[m_key[3:2]] = col[m_key[1:0]];
        chk("ready", req_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("row", row, er);
        if (done === 1'b1 && m_done) chk("done_lat", cyc - acc_cyc, 2 * B + m_hc);
        if (ph == 1 && !m_key[4] && col[m_key[1:0]] == 1'b0) begin
            if (prev_vld && row[m_key[3:2]] !== prev_r) tog++;
            prev_r = row[m_key[3:2]];
            prev_vld = 1;
        end else begin
            prev_vld = 0;
        end
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_nb = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (ph == 1 || ph == 3) m_nb++;
                m_t++;
                if (m_t == 2 * B + m_hc) begin
                    m_busy = 0; m_done = 1;
                end
            end else if (req_valid) begin
                m_busy = 1; m_t = 0; m_key = req_key;
                m_hc = (req_hold == 16'd0) ? 1 : int'(req_hold);
                acc_cyc = cyc;
            end
        end
        #1;
    endtask

    task automatic set_col(input int mode);
        logic [3:0] tbl [4];
        logic [1:0] c;
        c = m_key[1:0];
        tbl[0] = ~(4'b0001 << c);
        tbl[1] = ~(4'b0001 << (c + 2'd1));
        tbl[2] = 4'b0000;
        tbl[3] = 4'b1111;
        if (mode == 1) col = (phase() == 1) ? 4'b0000 : tbl[cyc % 4];
        else col = 4'($urandom);
    endtask

    // mode 0: random col, 1: directed col, 2: random col plus req_valid noise while busy
    task automatic run_req(input logic [4:0] key, input logic [15:0] hold, input int mode);
        int guard;
        req_valid = 1'b1; req_key = key; req_hold = hold;
        set_col(mode);
        cycle();
        req_valid = 1'b0;
        guard = 0;
        while (m_busy && guard < 300) begin
            set_col(mode);
            if (mode == 2) begin
                req_valid = 1'($urandom);
                req_key = 5'($urandom);
                req_hold = 16'($urandom_range(0, 3));
            end
            cycle();
            guard++;
        end
        req_valid = 1'b0;
        if (guard >= 300) chk("req_timeout", 0, 1);
    endtask

    initial begin
        col = 4'b0000;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();

        run_req(5'd1, 16'd10, 1);
        run_req(5'd10, 16'd5, 1);
        run_req(5'd7, 16'd3, 1);
        run_req(5'd3, 16'd6, 2);
        run_req(5'd16, 16'd0, 0);
        run_req(5'd13, 16'd0, 0);

        // reset while in HOLD
        req_valid = 1'b1; req_key = 5'd5; req_hold = 16'd20;
        col = 4'b0000;
        cycle();
        req_valid = 1'b0;
        for (int i = 0; i < B + 3; i++) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        for (int i = 0; i < 25; i++) begin
            run_req(5'($urandom_range(0, 31)), 16'($urandom_range(0, 20)), $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                col = 4'($urandom);
                cycle();
            end
        end

        chk("bounce_toggle", tog > 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
